// File: rtl/multi_access_pkg.sv
// Shared constants for the multi-player access controller: state encoding and width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package macc_pkg;

    localparam int STATE_W = 3;

    // Values 5..7 are illegal and recover to ENTRY.
    localparam logic [STATE_W-1:0] ENTRY   = 3'd0;
    localparam logic [STATE_W-1:0] CHECK   = 3'd1;
    localparam logic [STATE_W-1:0] GRANTED = 3'd2;
    localparam logic [STATE_W-1:0] FAIL    = 3'd3;
    localparam logic [STATE_W-1:0] LOCKOUT = 3'd4;

endpackage

// File: rtl/multi_access_if.sv
// Button/indicator bundle between the access controller and its environment.
// Latency: n/a (wires only).
// Backpressure: none; all inputs are single-cycle pulses that are never stalled.
interface multi_access_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int DIGIT_W     = 4,
    parameter int TRIES_W     = 2
);
    logic [DIGIT_W-1:0]           acc_data;
    logic                         acc_bpress;
    logic [NUM_PLAYERS-1:0]       player_bpress;
    logic [NUM_PLAYERS-1:0]       player_acc;
    logic                         pass_r;
    logic                         pass_g;
    logic [macc_pkg::STATE_W-1:0] acc_state;
    logic [TRIES_W-1:0]           tries;

    // Environment side: drives buttons, observes indicators.
    modport master (
        output acc_data, acc_bpress, player_bpress,
        input  player_acc, pass_r, pass_g, acc_state, tries
    );

    // Controller side.
    modport slave (
        input  acc_data, acc_bpress, player_bpress,
        output player_acc, pass_r, pass_g, acc_state, tries
    );
endinterface

// File: rtl/multi_access_acc_timer.sv
// Loadable, clearable up-counter with terminal-count flag (lockout / inactivity timing).
// Latency: count updates one edge after clr/ld/en; tc_o is a combinational compare of the count.
// Backpressure: none; clear has priority over load, load over increment.
module acc_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_dat_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, then load, then count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (ld_i) cnt_d = ld_dat_i;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);
endmodule

// File: rtl/multi_access.sv
// Password-gated player access controller with failed-try lockout; optional inactivity timeout under MACC_TIMEOUT_EN.
// Latency: grant visible 2 edges after the final digit edge; player_acc is player_bpress delayed by 1 cycle.
// Backpressure: none; presses outside ENTRY/GRANTED and player pulses outside GRANTED are dropped, never queued.
module multi_access
    import macc_pkg::*;
#(
    parameter int                          NUM_PLAYERS    = 2,
    parameter int                          DIGIT_W        = 4,
    parameter int                          PASS_LEN       = 4,
    parameter logic [PASS_LEN*DIGIT_W-1:0] PASSWORD       = 16'h3153,
    parameter int                          MAX_TRIES      = 3,
    parameter int                          LOCK_CYCLES    = 100,
    parameter int                          TIMEOUT_CYCLES = 1000
) (
    input logic           CLOCK,
    input logic           RESET,
    multi_access_if.slave bus
);
    localparam int CNT_W   = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [STATE_W-1:0]     state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   mismatch_q;
    logic [TRIES_W-1:0]     tries_q;
    logic [NUM_PLAYERS-1:0] player_acc_q;

    logic [DIGIT_W-1:0]     exp_digit;
    logic                   last_digit;
    logic                   lock_tc;
    logic                   to_hit;
    logic [LOCK_W-1:0]      lock_cnt_unused;

    // Expected digit for the current position; first digit entered is the MSB digit.
    always_comb begin
        exp_digit  = PASSWORD[(PASS_LEN - 1 - int'(cnt_q)) * DIGIT_W +: DIGIT_W];
        last_digit = (int'(cnt_q) == PASS_LEN - 1);
    end

    // Lockout timer: held at zero outside LOCKOUT, counts every LOCKOUT cycle.
    acc_timer #(.W(LOCK_W)) u_lock_timer (
        .clk      (CLOCK),
        .rst      (RESET),
        .clr_i    (state_q != LOCKOUT),
        .en_i     (1'b1),
        .ld_i     (1'b0),
        .ld_dat_i ('0),
        .term_i   (LOCK_W'(LOCK_CYCLES - 1)),
        .cnt_o    (lock_cnt_unused),
        .tc_o     (lock_tc)
    );

`ifdef MACC_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic            to_active;
    logic            to_reload;
    logic            to_tc;
    logic [TO_W-1:0] to_cnt_unused;

    // Inactivity window is open during a partial entry or while granted; any press restarts it.
    always_comb begin
        to_active = ((state_q == ENTRY) && (cnt_q != '0)) || (state_q == GRANTED);
        to_reload = bus.acc_bpress || (|bus.player_bpress);
    end

    acc_timer #(.W(TO_W)) u_to_timer (
        .clk      (CLOCK),
        .rst      (RESET),
        .clr_i    (!to_active || to_reload),
        .en_i     (1'b1),
        .ld_i     (1'b0),
        .ld_dat_i ('0),
        .term_i   (TO_W'(TIMEOUT_CYCLES - 1)),
        .cnt_o    (to_cnt_unused),
        .tc_o     (to_tc)
    );

    assign to_hit = to_tc && to_active && !to_reload;
`else
    assign to_hit = 1'b0;
`endif

    // Access FSM with registered player gating, digit count, sticky mismatch and try count.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ENTRY;
            cnt_q        <= '0;
            mismatch_q   <= 1'b0;
            tries_q      <= '0;
            player_acc_q <= '0;
        end else begin
            player_acc_q <= '0;
            case (state_q)
                ENTRY: begin
                    if (bus.acc_bpress) begin
                        if (bus.acc_data != exp_digit) mismatch_q <= 1'b1;
                        if (last_digit) begin
                            cnt_q   <= '0;
                            state_q <= CHECK;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (to_hit) begin
                        cnt_q      <= '0;
                        mismatch_q <= 1'b0;
                    end
                end
                CHECK: begin
                    mismatch_q <= 1'b0;
                    if (!mismatch_q) begin
                        state_q <= GRANTED;
                        tries_q <= '0;
                    end else begin
                        state_q <= FAIL;
                    end
                end
                FAIL: begin
                    if (int'(tries_q) < MAX_TRIES) tries_q <= tries_q + 1'b1;
                    if (int'(tries_q) + 1 >= MAX_TRIES) state_q <= LOCKOUT;
                    else                                state_q <= ENTRY;
                end
                LOCKOUT: begin
                    if (lock_tc) begin
                        state_q <= ENTRY;
                        tries_q <= '0;
                    end
                end
                GRANTED: begin
                    // Logout drops any player pulse arriving on the same edge.
                    if (bus.acc_bpress || to_hit) state_q <= ENTRY;
                    else                          player_acc_q <= bus.player_bpress;
                end
                default: begin
                    state_q    <= ENTRY;
                    cnt_q      <= '0;
                    mismatch_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.player_acc = player_acc_q;
    assign bus.pass_g     = (state_q == GRANTED);
    assign bus.pass_r     = (state_q != GRANTED);
    assign bus.acc_state  = state_q;
    assign bus.tries      = tries_q;
endmodule
